// File: rtl/char_motion_pkg.sv
// ---------------------------------------------------------------------------
// char_motion_pkg : shared state encoding and screen/sprite geometry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package char_motion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } state_t;

  localparam int CHAR_W   = 21;
  localparam int CHAR_H   = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

`default_nettype wire

// File: rtl/char_motion_btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync : two-flop synchroniser for one asynchronous push-button
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_sync
  import char_motion_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = btn_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign btn_out = sync_q;

endmodule

`default_nettype wire

// File: rtl/char_motion.sv
// ---------------------------------------------------------------------------
// char_motion : per-frame player position controller with jump/gravity FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module char_motion
  import char_motion_pkg::*;
#(
  parameter int X_START    = 50,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 619,
  parameter int GROUND_TOP = 400,
  parameter int JUMP_V     = 12,
  parameter int VMAX       = 12,
  parameter int TICK_LINE  = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [9:0]  char_left,
  output logic [9:0]  char_top,
  output logic        airborne,
  output logic        frame_tick
);

  localparam logic [9:0]  c_x_start    = 10'(X_START);
  localparam logic [9:0]  c_x_min      = 10'(X_MIN);
  localparam logic [9:0]  c_x_max      = 10'(X_MAX);
  localparam logic [9:0]  c_ground_top = 10'(GROUND_TOP);
  localparam logic [3:0]  c_jump_v     = 4'(JUMP_V);
  localparam logic [3:0]  c_vmax       = 4'(VMAX);
  localparam logic [10:0] c_tick_line  = 11'(TICK_LINE);

  logic [2:0] btn_raw;
  logic [2:0] btn_s;
  logic       left_s, right_s, jump_s;

  assign btn_raw = {btn_jump, btn_right, btn_left};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    btn_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_raw[gi]),
      .btn_out(btn_s[gi])
    );
  end

  assign left_s  = btn_s[0];
  assign right_s = btn_s[1];
  assign jump_s  = btn_s[2];

  logic       frame_tick_q, frame_tick_d;
  logic [9:0] char_left_q, char_left_d;
  logic [9:0] char_top_q, char_top_d;
  logic       airborne_q, airborne_d;
  state_t     state_q, state_d;
  logic [3:0] vel_q, vel_d;
  logic       jump_armed_q, jump_armed_d;

  logic [4:0]  vel_inc;
  logic [3:0]  fall_v;
  logic [10:0] fall_sum;

  always_comb begin
    frame_tick_d = (hcount == 11'd0) && (vcount == c_tick_line);
    char_left_d  = char_left_q;
    char_top_d   = char_top_q;
    state_d      = state_q;
    vel_d        = vel_q;
    jump_armed_d = jump_armed_q;

    vel_inc  = {1'b0, vel_q} + 5'd1;
    fall_v   = (vel_inc > {1'b0, c_vmax}) ? c_vmax : vel_inc[3:0];
    // Landing compare is one bit wider than char_top so it cannot wrap.
    fall_sum = {1'b0, char_top_q} + {7'd0, fall_v};

    if (frame_tick_q) begin
      if (right_s && !left_s && (char_left_q < c_x_max)) begin
        char_left_d = char_left_q + 10'd1;
      end else if (left_s && !right_s && (char_left_q > c_x_min)) begin
        char_left_d = char_left_q - 10'd1;
      end

      if (!jump_s) begin
        jump_armed_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (jump_s && jump_armed_q) begin
            state_d      = RISE;
            vel_d        = c_jump_v;
            jump_armed_d = 1'b0;
          end
        end
        RISE: begin
          if (char_top_q < {6'd0, vel_q}) begin
            char_top_d = 10'd0;
            vel_d      = 4'd0;
            state_d    = FALL;
          end else begin
            char_top_d = char_top_q - {6'd0, vel_q};
            vel_d      = vel_q - 4'd1;
            if (vel_q == 4'd1) begin
              state_d = FALL;
            end
          end
        end
        FALL: begin
          if (fall_sum >= {1'b0, c_ground_top}) begin
            char_top_d = c_ground_top;
            vel_d      = 4'd0;
            state_d    = IDLE;
          end else begin
            char_top_d = fall_sum[9:0];
            vel_d      = fall_v;
          end
        end
        default: begin
          state_d = IDLE;
          vel_d   = 4'd0;
        end
      endcase
    end

    airborne_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick_q <= 1'b0;
      char_left_q  <= c_x_start;
      char_top_q   <= c_ground_top;
      airborne_q   <= 1'b0;
      state_q      <= IDLE;
      vel_q        <= 4'd0;
      jump_armed_q <= 1'b1;
    end else begin
      frame_tick_q <= frame_tick_d;
      char_left_q  <= char_left_d;
      char_top_q   <= char_top_d;
      airborne_q   <= airborne_d;
      state_q      <= state_d;
      vel_q        <= vel_d;
      jump_armed_q <= jump_armed_d;
    end
  end

  assign char_left  = char_left_q;
  assign char_top   = char_top_q;
  assign airborne   = airborne_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_char_motion.sv
// ---------------------------------------------------------------------------
// tb_char_motion : vector table, corner sequences and random run vs. model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_char_motion;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = 11'd100;
  logic [10:0] vcount = 11'd100;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_jump = 1'b0;
  logic [9:0]  char_left, char_top, c_left, c_top;
  logic        airborne, frame_tick, c_air, c_tick;

  always #5 clk = ~clk;

  char_motion u_dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .char_left(char_left), .char_top(char_top), .airborne(airborne),
    .frame_tick(frame_tick)
  );

  char_motion #(.GROUND_TOP(40), .JUMP_V(15)) u_ceil (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .char_left(c_left), .char_top(c_top), .airborne(c_air),
    .frame_tick(c_tick)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: positions and speed as plain integers, phase 0/1/2 = ground/up/down.
  int m_left, m_top, m_vel, m_phase;
  bit m_armed;

  task automatic model_reset();
    m_left = 50; m_top = 400; m_vel = 0; m_phase = 0; m_armed = 1'b1;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int nv;
    if (r && !l) m_left = (m_left + 1 > 619) ? 619 : m_left + 1;
    else if (l && !r) m_left = (m_left - 1 < 0) ? 0 : m_left - 1;
    if (m_phase == 0) begin
      if (j && m_armed) begin
        m_phase = 1; m_vel = 12; m_armed = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (m_top < m_vel) begin
        m_top = 0; m_vel = 0; m_phase = 2;
      end else begin
        m_top = m_top - m_vel;
        m_vel = m_vel - 1;
        if (m_vel == 0) m_phase = 2;
      end
    end else begin
      nv = (m_vel + 1 > 12) ? 12 : m_vel + 1;
      if (m_top + nv >= 400) begin
        m_top = 400; m_vel = 0; m_phase = 0;
      end else begin
        m_top = m_top + nv; m_vel = nv;
      end
    end
    if (!j) m_armed = 1'b1;
  endtask

  task automatic set_btn(input bit l, input bit r, input bit j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    repeat (3) @(negedge clk);
  endtask

  // One frame tick; returns at the negedge after the update edge.
  task automatic do_tick();
    hcount = 11'd0; vcount = 11'd480;
    @(negedge clk);
    hcount = 11'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; hcount = 11'd0; vcount = 11'd480;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left", char_left, 50);
    check("rst_top", char_top, 400);
    check("rst_air", airborne, 0);
    check("rst_tick", frame_tick, 0);
    reset = 1'b0; hcount = 11'd1;
    model_reset();
  endtask

  typedef struct {
    bit l; bit r; bit j;
    int ticks;
    int e_left; int e_top; bit e_air;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 1, 0, 10, 60, 400, 0};
    vecs[1]  = '{1, 1, 0,  5, 60, 400, 0};
    vecs[2]  = '{0, 0, 0,  3, 60, 400, 0};
    vecs[3]  = '{1, 0, 0,  4, 56, 400, 0};
    vecs[4]  = '{0, 0, 1,  1, 56, 400, 1};
    vecs[5]  = '{0, 0, 1, 12, 56, 322, 1};
    vecs[6]  = '{0, 0, 1, 12, 56, 400, 0};
    vecs[7]  = '{0, 0, 1,  2, 56, 400, 0};
    vecs[8]  = '{0, 0, 0,  1, 56, 400, 0};
    vecs[9]  = '{0, 0, 1,  1, 56, 400, 1};
    vecs[10] = '{0, 1, 1,  3, 59, 367, 1};
    vecs[11] = '{0, 0, 0, 21, 59, 400, 0};

    do_reset();

    // Tick pulse timing
    hcount = 11'd0; vcount = 11'd480;
    check("tick_pre", frame_tick, 0);
    @(negedge clk);
    hcount = 11'd1;
    check("tick_pulse", frame_tick, 1);
    @(negedge clk);
    check("tick_clear", frame_tick, 0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_btn(vecs[i].l, vecs[i].r, vecs[i].j);
      repeat (vecs[i].ticks) do_tick();
      check($sformatf("vec%0d_left", i), char_left, vecs[i].e_left);
      check($sformatf("vec%0d_top", i), char_top, vecs[i].e_top);
      check($sformatf("vec%0d_air", i), airborne, vecs[i].e_air);
    end

    // Right edge clamp
    do_reset();
    set_btn(0, 1, 0);
    repeat (568) do_tick();
    check("right_618", char_left, 618);
    repeat (3) do_tick();
    check("right_clamp", char_left, 619);

    // Left edge clamp
    do_reset();
    set_btn(1, 0, 0);
    repeat (50) do_tick();
    check("left_0", char_left, 0);
    repeat (3) do_tick();
    check("left_clamp", char_left, 0);

    // Ceiling hit on the low-ground instance
    do_reset();
    set_btn(0, 0, 1);
    do_tick();
    check("ceil_launch_top", c_top, 40);
    check("ceil_launch_air", c_air, 1);
    do_tick();
    check("ceil_t1", c_top, 25);
    do_tick();
    check("ceil_t2", c_top, 11);
    do_tick();
    check("ceil_hit_top", c_top, 0);
    check("ceil_hit_air", c_air, 1);
    do_tick();
    check("ceil_fall_top", c_top, 1);

    // Reset in the middle of a rise
    do_reset();
    set_btn(0, 0, 1);
    do_tick();
    do_tick();
    check("rise_top", char_top, 388);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_top", char_top, 400);
    check("midrst_air", airborne, 0);
    check("midrst_left", char_left, 50);
    reset = 1'b0;
    btn_jump = 1'b0;

    // Button chatter between ticks must not move anything
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn_right = 1'($urandom_range(0, 1));
      btn_jump  = 1'(i % 2);
      btn_left  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("chatter_left", char_left, 50);
    check("chatter_top", char_top, 400);
    check("chatter_air", airborne, 0);
    set_btn(0, 1, 0);
    do_tick();
    check("after_chatter_left", char_left, 51);

    // Random run against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bit l, r, j;
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      j = 1'($urandom_range(0, 1));
      set_btn(l, r, j);
      do_tick();
      model_tick(l, r, j);
      check($sformatf("rnd%0d_left", i), char_left, m_left);
      check($sformatf("rnd%0d_top", i), char_top, m_top);
      check($sformatf("rnd%0d_air", i), airborne, (m_phase != 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
